// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-side pointer and flag control for the asynchronous FIFO
//
// Write-domain half of an async FIFO. Produces the memory write enable/address,
// the registered Gray write pointer for the read-domain synchronizer, and the
// full / almost-full / level / sticky-overflow flags computed against the read
// pointer that has already been synchronized into this clock domain.
//
// Parameters
//   ADDR_WIDTH     memory address bits (depth = 2**ADDR_WIDTH), >= 2
//   AF_THRESH      almost-full asserts when level >= AF_THRESH, 1..2**ADDR_WIDTH
//
// Ports
//   clk_i          write-domain clock
//   rst_ni         synchronous active-low reset
//   w_inc_i        write request from the producer
//   ovf_clr_i      clears the sticky overflow flag
//   sync_rd_ptr_i  Gray read pointer, already synchronized into clk_i
//   w_en_o         memory write enable (combinational, request & not full)
//   w_addr_o       memory write address (low bits of binary write pointer)
//   w_gray_ptr_o   registered Gray write pointer to the read-domain synchronizer
//   full_o         registered full flag
//   almost_full_o  registered almost-full flag
//   w_level_o      registered fill level, 0..2**ADDR_WIDTH
//   w_overflow_o   sticky flag, set by a write attempted while full

module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  w_inc_i,
    input  logic                  ovf_clr_i,
    input  logic [ADDR_WIDTH:0]   sync_rd_ptr_i,
    output logic                  w_en_o,
    output logic [ADDR_WIDTH-1:0] w_addr_o,
    output logic [ADDR_WIDTH:0]   w_gray_ptr_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH:0]   w_level_o,
    output logic                  w_overflow_o
);

    localparam int P = ADDR_WIDTH + 1;

    logic [P-1:0] wbin_q,  wbin_d;
    logic [P-1:0] wgray_q, wgray_d;
    logic         full_q,  full_d;
    logic         af_q,    af_d;
    logic [P-1:0] level_q, level_d;
    logic         ovf_q,   ovf_d;
    logic [P-1:0] rbin;
    logic         w_en;

    assign w_en = w_inc_i & ~full_q;

    // Gray-to-binary of the synchronized read pointer: each binary bit is the
    // XOR of all Gray bits at or above it.
    always_comb begin
        rbin        = '0;
        rbin[P-1]   = sync_rd_ptr_i[P-1];
        for (int i = P - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ sync_rd_ptr_i[i];
        end
    end

    always_comb begin
        wbin_d  = wbin_q + {{(P-1){1'b0}}, w_en};
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        // Full when the next write pointer is exactly one lap ahead of the read
        // pointer: in Gray form that is the two MSBs inverted, the rest equal.
        full_d  = (wgray_d == {~sync_rd_ptr_i[P-1:P-2], sync_rd_ptr_i[P-3:0]});
        // Modulo-2^P subtraction keeps the level correct across pointer wrap.
        level_d = wbin_d - rbin;
        af_d    = (level_d >= P'(AF_THRESH));
        ovf_d   = ovf_q;
        if (w_inc_i && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            af_q    <= af_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_en_o        = w_en;
    assign w_addr_o      = wbin_q[ADDR_WIDTH-1:0];
    // Straight from the flop so the synchronizer only ever sees one-bit changes.
    assign w_gray_ptr_o  = wgray_q;
    assign full_o        = full_q;
    assign almost_full_o = af_q;
    assign w_level_o     = level_q;
    assign w_overflow_o  = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - self-checking bench for fifo_wr_ctrl

module tb_fifo_wr_ctrl;

    localparam int AW    = 3;
    localparam int P     = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int MODP  = 1 << P;
    localparam int AFT   = 6;

    logic          clk;
    logic          rst_n;
    logic          w_inc;
    logic          ovf_clr;
    logic [P-1:0]  sync_rd_ptr;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [P-1:0]  w_gray_ptr;
    logic          full;
    logic          almost_full;
    logic [P-1:0]  w_level;
    logic          w_overflow;

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(AFT)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .w_inc_i       (w_inc),
        .ovf_clr_i     (ovf_clr),
        .sync_rd_ptr_i (sync_rd_ptr),
        .w_en_o        (w_en),
        .w_addr_o      (w_addr),
        .w_gray_ptr_o  (w_gray_ptr),
        .full_o        (full),
        .almost_full_o (almost_full),
        .w_level_o     (w_level),
        .w_overflow_o  (w_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: number of committed writes mod 2^P and the flags it implies.
    int m_wbin  = 0;
    int m_level = 0;
    bit m_full  = 0;
    bit m_af    = 0;
    bit m_ovf   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P-1:0] to_gray(input int b);
        logic [P-1:0] v;
        v = P'(b);
        return v ^ (v >> 1);
    endfunction

    // One clock cycle: drive inputs, check the combinational outputs before the
    // edge, advance the model, check the registered outputs after the edge.
    task automatic step(input bit rst, input bit inc, input bit clr, input int rd);
        bit exp_wen;
        @(negedge clk);
        rst_n       = rst;
        w_inc       = inc;
        ovf_clr     = clr;
        sync_rd_ptr = to_gray(rd);
        #1;
        exp_wen = inc && !m_full;
        chk("w_en", 32'(w_en), 32'(exp_wen));
        chk("w_addr_pre", 32'(w_addr), 32'(m_wbin % DEPTH));
        @(posedge clk);
        if (!rst) begin
            m_wbin = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            if (inc && m_full)  m_ovf = 1;
            else if (clr)       m_ovf = 0;
            m_wbin  = (m_wbin + int'(exp_wen)) % MODP;
            m_level = (m_wbin - rd) & (MODP - 1);
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= AFT);
        end
        #1;
        chk("w_addr",      32'(w_addr),      32'(m_wbin % DEPTH));
        chk("w_gray_ptr",  32'(w_gray_ptr),  32'(to_gray(m_wbin)));
        chk("full",        32'(full),        32'(m_full));
        chk("almost_full", 32'(almost_full), 32'(m_af));
        chk("w_level",     32'(w_level),     32'(m_level));
        chk("w_overflow",  32'(w_overflow),  32'(m_ovf));
    endtask

    initial begin
        int  rd;
        int  guard;
        bit  wrapped;

        rst_n = 1'b0; w_inc = 1'b1; ovf_clr = 1'b0; sync_rd_ptr = '0;
        @(posedge clk);
        // Reset held with a write request: everything stays zero, w_en follows w_inc.
        step(0, 1, 0, 0);
        chk("rst_w_en_during", 32'(w_en), 32'd1);
        chk("rst_level", 32'(w_level), 32'd0);

        // Fill eight entries with the reader parked at 0.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 1, 0, 0);
            if (i == 6) chk("af_after_6", 32'(almost_full), 32'd1);
            if (i == 5) chk("af_after_5", 32'(almost_full), 32'd0);
        end
        chk("fill_full",  32'(full),       32'd1);
        chk("fill_level", 32'(w_level),    32'd8);
        chk("fill_gray",  32'(w_gray_ptr), 32'b1100);
        chk("fill_addr",  32'(w_addr),     32'd0);

        // Overflow set, hold, clear, and set-beats-clear.
        step(1, 1, 0, 0);
        chk("ovf_set",   32'(w_overflow), 32'd1);
        chk("ovf_gray",  32'(w_gray_ptr), 32'b1100);
        step(1, 0, 0, 0);
        chk("ovf_hold",  32'(w_overflow), 32'd1);
        step(1, 0, 1, 0);
        chk("ovf_clr",   32'(w_overflow), 32'd0);
        step(1, 1, 1, 0);
        chk("ovf_prio",  32'(w_overflow), 32'd1);

        // Reader advances while full.
        step(1, 0, 0, 2);
        chk("rel_full",  32'(full),        32'd0);
        chk("rel_level", 32'(w_level),     32'd6);
        chk("rel_af",    32'(almost_full), 32'd1);
        step(1, 0, 0, 3);
        chk("rel3_level", 32'(w_level),     32'd5);
        chk("rel3_af",    32'(almost_full), 32'd0);

        // Stream through the pointer wrap with the reader trailing, then land on
        // wbin=4 and a reader at 12: full again, level 8.
        wrapped = 0;
        guard   = 0;
        while (!(wrapped && m_wbin == 4) && guard < 64) begin
            step(1, 1, 0, (m_wbin - 4) & (MODP - 1));
            if (m_wbin == 15) chk("wrap_gray15", 32'(w_gray_ptr), 32'b1000);
            if (m_wbin == 0) begin
                wrapped = 1;
                chk("wrap_gray0", 32'(w_gray_ptr), 32'b0000);
            end
            guard++;
        end
        chk("wrap_reached", 32'(guard < 64), 32'd1);
        step(1, 0, 0, 12);
        chk("wrap_full",  32'(full),       32'd1);
        chk("wrap_level", 32'(w_level),    32'd8);
        chk("wrap_gray4", 32'(w_gray_ptr), 32'b0110);

        // Mid-burst reset after five writes.
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        chk("mb_addr5", 32'(w_addr), 32'd5);
        step(0, 1, 0, 0);
        chk("mb_rst_addr", 32'(w_addr),     32'd0);
        chk("mb_rst_gray", 32'(w_gray_ptr), 32'd0);
        step(1, 1, 0, 0);
        chk("mb_resume", 32'(w_addr), 32'd1);

        // Randomized traffic: reader only advances over entries already written.
        rd = 0;
        for (int c = 0; c < 600; c++) begin
            bit r_rst, r_inc, r_clr;
            r_rst = ($urandom_range(0, 99) != 0);
            r_inc = ($urandom_range(0, 99) < 65);
            r_clr = ($urandom_range(0, 9) == 0);
            if (((m_wbin - rd) & (MODP - 1)) != 0 && $urandom_range(0, 99) < 40)
                rd = (rd + 1) % MODP;
            step(r_rst, r_inc, r_clr, rd);
            if (!r_rst) rd = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
